psum_accum_ctrl: RTL and testbench
==================================

# psum_accum_ctrl

Read-modify-write controller for the psum global buffer. Accepts one partial sum per cycle from the PE-array output path and reads the stored psum, or the bias on a channel's first pass. It adds the two with signed saturation, optionally applies ReLU on the last pass, and writes the result back. It also arbitrates psum port B between accumulation reads and the DRAM drain reader, with a bounded-starvation rule. Sits between the PE array and the psum/bias ports of the GLB unit.

## Interface
Parameters:
- DATA_WIDTH, 16, psum/bias word width (two's complement)
- DEPTH_psum, 193600, psum GLB depth; ADDR_psum = $clog2(DEPTH_psum)
- DEPTH_bias, 384, bias GLB depth; ADDR_bias = $clog2(DEPTH_bias)
- STARVE_MAX, 8, max consecutive accumulation cycles while a drain request waits

Ports:
- core_clk  in  1  clock; only clock
- core_reset  in  1  reset, synchronous, active-high
- in_valid / in_ready  in / out  1 / 1  psum input handshake
- in_data  in  DATA_WIDTH  incoming partial sum
- in_addr  in  ADDR_psum  psum GLB address
- in_first  in  1  first pass: add bias instead of stored psum
- in_last  in  1  last pass: apply ReLU before write
- in_bias_idx  in  ADDR_bias  bias entry for this psum
- re_b_psum / addr_b_psum  out  1 / ADDR_psum  psum port B read
- rdata_b_psum  in  DATA_WIDTH  port B data, 1-cycle latency
- we_a_psum / addr_a_psum / wdata_a_psum  out  1 / ADDR_psum / DATA_WIDTH  psum port A write
- re_bias / raddr_bias  out  1 / ADDR_bias  bias read
- rdata_bias  in  DATA_WIDTH  bias data, 1-cycle latency
- rd_req / rd_addr  in  1 / ADDR_psum  drain read request
- rd_gnt  out  1  drain request granted this cycle
- rd_valid / rd_data  out  1 / DATA_WIDTH  drain data, cycle after rd_gnt
- busy  out  1  accumulation in flight (S1 or S2 valid)

## Operation
- Two-stage pipeline. S1: accept, issue read. S2: read data returns, add, write.
- Accept (in_valid & in_ready):
  - in_first=0: re_b_psum=1, addr_b_psum=in_addr.
  - in_first=1: re_bias=1, raddr_bias=in_bias_idx; no psum read.
  - addr, data, first and last are registered into S2.
- S2 operand:
  - first: rdata_bias.
  - not first, forward flag set: registered previous sum.
  - otherwise: rdata_b_psum.
- Forward flag is set at accept when not first, S2 is valid, and in_addr equals S2's address. This covers back-to-back same-address accumulation; the RAM's read-during-write behaviour is never relied on.
- sum = saturate(in_data + operand). The add uses DATA_WIDTH+1 bits and clamps to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
- If last and sum<0, the written value is 0. The forward register holds the written value.
- S2 drives we_a_psum=1, addr_a_psum=S2 address, wdata_a_psum=result. This is combinational from S2 registers and read data.
- Arbiter: starve counter counts accepted cycles while rd_req=1.
  - Grant rd_gnt = rd_req & (~in_valid | cnt==STARVE_MAX).
  - in_ready = ~(rd_req & cnt==STARVE_MAX).
  - Counter clears on rd_gnt or when rd_req=0.
- Grant drives re_b_psum=1, addr_b_psum=rd_addr. rd_valid=1 next cycle with rd_data=rdata_b_psum.
- A drain grant never coincides with an accumulation read. First-pass accepts don't use port B, but still block rd_gnt; the rule is kept uniform.
- Drain coherence is the sequencer's responsibility: it issues rd_req only after the final pass is written.

## Timing
- Reset clears all S1/S2 valids, the forward flag and the starve counter.
- Reset values: in_ready=1, rd_gnt=0, rd_valid=0, busy=0. we_a_psum, re_b_psum and re_bias are 0; all address and data outputs are 0.
- Reset mid-operation: in-flight S2 write is dropped; no write occurs in the cycle after reset.
- Latency: accept at cycle t, write at t+1. Throughput 1/cycle, no bubbles for same-address sequences.
- busy=1 from accept cycle through the write cycle.
- Drain latency: rd_gnt at t, rd_valid at t+1.

## Structure
- Shared package glb_pkg: DATA_WIDTH, the saturation min/max constants, and a psum_req_t struct (data, addr, first, last, bias_idx).
- One sub-module, sat_add: signed saturating adder with optional ReLU, combinational.
- Arbiter and pipeline stay in psum_accum_ctrl.

## Test plan
- Single request, first=1, in_data=5, bias=3, addr=10 -> re_bias at t; write addr 10 data 8 at t+1.
- Same address twice back-to-back: stored 100, in_data 1 then 2, first=0 -> writes 101 then 103; second operand forwarded, not read from RAM.
- Saturation: stored 0x7FF0, in_data 0x0100 -> writes 0x7FFF. Stored 0x8010, in_data 0xFF00 -> writes 0x8000.
- ReLU: last=1, stored -20, in_data 5 -> writes 0. last=1, stored 20, in_data 5 -> writes 25.
- Starvation: continuous in_valid with rd_req held -> rd_gnt after exactly 8 accepts, in_ready=0 that cycle, rd_valid next cycle with the stored value.
- Reset asserted the cycle after an accept -> no we_a_psum pulse; all outputs at reset values the following cycle.

Source files
------------

// File: rtl/glb_pkg.sv
// Shared GLB types and constants for the psum accumulation path.
package glb_pkg;

  localparam int unsigned DATA_WIDTH = 16;
  localparam int unsigned DEPTH_PSUM = 193600;
  localparam int unsigned DEPTH_BIAS = 384;
  localparam int unsigned ADDR_PSUM  = $clog2(DEPTH_PSUM);
  localparam int unsigned ADDR_BIAS  = $clog2(DEPTH_BIAS);

  // Two's complement clamp limits for a DATA_WIDTH word
  localparam logic [DATA_WIDTH-1:0] SAT_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [DATA_WIDTH-1:0] SAT_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  // One accumulation request as presented by the PE-array output path
  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [ADDR_PSUM-1:0]  addr;
    logic                  first;
    logic                  last;
    logic [ADDR_BIAS-1:0]  bias_idx;
  } psum_req_t;

endpackage

// File: rtl/sat_add.sv
// Signed saturating adder with optional ReLU on the clamped result.
module sat_add
  import glb_pkg::*;
(
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic                  relu,
  output logic [DATA_WIDTH-1:0] y
);

  logic [DATA_WIDTH:0]   sum_wide;
  logic [DATA_WIDTH-1:0] sat;

  // Sign-extend by one bit; overflow shows as disagreement of the top two bits
  always_comb begin
    sum_wide = {a[DATA_WIDTH-1], a} + {b[DATA_WIDTH-1], b};
    if (sum_wide[DATA_WIDTH] != sum_wide[DATA_WIDTH-1]) begin
      sat = sum_wide[DATA_WIDTH] ? SAT_MIN : SAT_MAX;
    end else begin
      sat = sum_wide[DATA_WIDTH-1:0];
    end
    y = (relu && sat[DATA_WIDTH-1]) ? '0 : sat;
  end

endmodule

// File: rtl/psum_accum_ctrl.sv
// Psum read-modify-write pipeline plus port-B arbitration against the drain reader.
module psum_accum_ctrl
  import glb_pkg::psum_req_t;
#(
  parameter int unsigned DATA_WIDTH = glb_pkg::DATA_WIDTH,
  parameter int unsigned DEPTH_psum = glb_pkg::DEPTH_PSUM,
  parameter int unsigned DEPTH_bias = glb_pkg::DEPTH_BIAS,
  parameter int unsigned STARVE_MAX = 8,
  localparam int unsigned ADDR_psum = $clog2(DEPTH_psum),
  localparam int unsigned ADDR_bias = $clog2(DEPTH_bias)
) (
  input  logic                  core_clk,
  input  logic                  core_reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [ADDR_psum-1:0]  in_addr,
  input  logic                  in_first,
  input  logic                  in_last,
  input  logic [ADDR_bias-1:0]  in_bias_idx,
  output logic                  re_b_psum,
  output logic [ADDR_psum-1:0]  addr_b_psum,
  input  logic [DATA_WIDTH-1:0] rdata_b_psum,
  output logic                  we_a_psum,
  output logic [ADDR_psum-1:0]  addr_a_psum,
  output logic [DATA_WIDTH-1:0] wdata_a_psum,
  output logic                  re_bias,
  output logic [ADDR_bias-1:0]  raddr_bias,
  input  logic [DATA_WIDTH-1:0] rdata_bias,
  input  logic                  rd_req,
  input  logic [ADDR_psum-1:0]  rd_addr,
  output logic                  rd_gnt,
  output logic                  rd_valid,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  busy
);

  localparam int unsigned CNT_W = $clog2(STARVE_MAX + 1);

  psum_req_t             req;
  logic                  accept;
  logic                  at_max;
  logic                  s2_we;
  logic                  rd_show;
  logic [DATA_WIDTH-1:0] operand;
  logic [DATA_WIDTH-1:0] result;

  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  s2_valid_q, s2_valid_d;
  logic [DATA_WIDTH-1:0] s2_data_q, s2_data_d;
  logic [ADDR_psum-1:0]  s2_addr_q, s2_addr_d;
  logic                  s2_first_q, s2_first_d;
  logic                  s2_last_q, s2_last_d;
  logic                  fwd_q, fwd_d;
  logic [DATA_WIDTH-1:0] fwd_data_q, fwd_data_d;
  logic                  rd_valid_q, rd_valid_d;

  // Bundle the incoming request
  always_comb begin
    req = '{data: in_data, addr: in_addr, first: in_first, last: in_last,
            bias_idx: in_bias_idx};
  end

  // Arbitration: drain wins on idle input or once accumulation has starved it
  always_comb begin
    at_max   = (cnt_q == CNT_W'(STARVE_MAX));
    in_ready = core_reset | ~(rd_req & at_max);
    accept   = ~core_reset & in_valid & ~(rd_req & at_max);
    rd_gnt   = ~core_reset & rd_req & (~in_valid | at_max);
  end

  // Read-port drive for accept (S1) and drain grant; the two never overlap
  always_comb begin
    re_b_psum   = 1'b0;
    addr_b_psum = '0;
    re_bias     = 1'b0;
    raddr_bias  = '0;
    if (rd_gnt) begin
      re_b_psum   = 1'b1;
      addr_b_psum = rd_addr;
    end else if (accept && !req.first) begin
      re_b_psum   = 1'b1;
      addr_b_psum = req.addr;
    end
    if (accept && req.first) begin
      re_bias    = 1'b1;
      raddr_bias = req.bias_idx;
    end
  end

  // S2 operand select; forwarded sum avoids relying on RAM read-during-write
  always_comb begin
    s2_we = ~core_reset & s2_valid_q;
    if (s2_first_q) begin
      operand = rdata_bias;
    end else if (fwd_q) begin
      operand = fwd_data_q;
    end else begin
      operand = rdata_b_psum;
    end
  end

  sat_add u_sat_add (
    .a    (s2_data_q),
    .b    (operand),
    .relu (s2_last_q),
    .y    (result)
  );

  // S2 write port, drain data and status
  always_comb begin
    we_a_psum    = s2_we;
    addr_a_psum  = s2_we ? s2_addr_q : '0;
    wdata_a_psum = s2_we ? result : '0;
    rd_show      = ~core_reset & rd_valid_q;
    rd_valid     = rd_show;
    rd_data      = rd_show ? rdata_b_psum : '0;
    busy         = accept | s2_we;
  end

  // Next-state for pipeline, forward path and starve counter
  always_comb begin
    s2_valid_d = accept;
    s2_data_d  = s2_data_q;
    s2_addr_d  = s2_addr_q;
    s2_first_d = s2_first_q;
    s2_last_d  = s2_last_q;
    fwd_d      = accept & ~req.first & s2_valid_q & (req.addr == s2_addr_q);
    fwd_data_d = s2_we ? result : fwd_data_q;
    rd_valid_d = rd_gnt;
    cnt_d      = cnt_q;
    if (accept) begin
      s2_data_d  = req.data;
      s2_addr_d  = req.addr;
      s2_first_d = req.first;
      s2_last_d  = req.last;
    end
    if (!rd_req || rd_gnt) begin
      cnt_d = '0;
    end else if (accept) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge core_clk) begin
    if (core_reset) begin
      cnt_q      <= '0;
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
      s2_addr_q  <= '0;
      s2_first_q <= 1'b0;
      s2_last_q  <= 1'b0;
      fwd_q      <= 1'b0;
      fwd_data_q <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      s2_valid_q <= s2_valid_d;
      s2_data_q  <= s2_data_d;
      s2_addr_q  <= s2_addr_d;
      s2_first_q <= s2_first_d;
      s2_last_q  <= s2_last_d;
      fwd_q      <= fwd_d;
      fwd_data_q <= fwd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

endmodule

// File: tb/tb_psum_accum_ctrl.sv
// Scoreboard bench for psum_accum_ctrl with behavioural psum/bias RAMs.
module tb_psum_accum_ctrl;

  localparam int unsigned DW = 16;
  localparam int unsigned AW = 18;
  localparam int unsigned BW = 9;

  logic          core_clk = 1'b0;
  logic          core_reset;
  logic          in_valid, in_ready, in_first, in_last;
  logic [DW-1:0] in_data;
  logic [AW-1:0] in_addr;
  logic [BW-1:0] in_bias_idx;
  logic          re_b_psum;
  logic [AW-1:0] addr_b_psum;
  logic [DW-1:0] rdata_b_psum = '0;
  logic          we_a_psum;
  logic [AW-1:0] addr_a_psum;
  logic [DW-1:0] wdata_a_psum;
  logic          re_bias;
  logic [BW-1:0] raddr_bias;
  logic [DW-1:0] rdata_bias = '0;
  logic          rd_req;
  logic [AW-1:0] rd_addr;
  logic          rd_gnt, rd_valid, busy;
  logic [DW-1:0] rd_data;

  always #5 core_clk = ~core_clk;

  psum_accum_ctrl dut (
    .core_clk     (core_clk),
    .core_reset   (core_reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .in_addr      (in_addr),
    .in_first     (in_first),
    .in_last      (in_last),
    .in_bias_idx  (in_bias_idx),
    .re_b_psum    (re_b_psum),
    .addr_b_psum  (addr_b_psum),
    .rdata_b_psum (rdata_b_psum),
    .we_a_psum    (we_a_psum),
    .addr_a_psum  (addr_a_psum),
    .wdata_a_psum (wdata_a_psum),
    .re_bias      (re_bias),
    .raddr_bias   (raddr_bias),
    .rdata_bias   (rdata_bias),
    .rd_req       (rd_req),
    .rd_addr      (rd_addr),
    .rd_gnt       (rd_gnt),
    .rd_valid     (rd_valid),
    .rd_data      (rd_data),
    .busy         (busy)
  );

  // Initial RAM contents for the directed vectors
  function automatic logic [DW-1:0] init_psum(input logic [7:0] a);
    case (a)
      8'd20:   return 16'd100;
      8'd30:   return 16'h7FF0;
      8'd31:   return 16'h8010;
      8'd40:   return 16'hFFEC;
      8'd41:   return 16'd20;
      8'd50:   return 16'h1234;
      default: return 16'h0000;
    endcase
  endfunction

  function automatic logic [DW-1:0] bias_val(input logic [BW-1:0] idx);
    return (idx == 9'd7) ? 16'd3 : 16'd0;
  endfunction

  // Psum RAM (read returns old data on same-address write) and bias ROM, 1-cycle reads
  logic [DW-1:0] psum_mem [0:255];
  bit            written  [0:255];
  always @(posedge core_clk) begin
    if (we_a_psum) begin
      psum_mem[addr_a_psum[7:0]] <= wdata_a_psum;
      written[addr_a_psum[7:0]]  <= 1'b1;
    end
    if (re_b_psum)
      rdata_b_psum <= written[addr_b_psum[7:0]] ? psum_mem[addr_b_psum[7:0]]
                                                : init_psum(addr_b_psum[7:0]);
    if (re_bias)
      rdata_bias <= bias_val(raddr_bias);
  end

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  wr_t           wr_q [$];
  logic [DW-1:0] rd_q [$];
  int            n_cmp = 0;
  int            n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every write and every drain return is matched against the queues
  initial begin
    wr_t           e;
    logic [DW-1:0] d;
    forever begin
      @(negedge core_clk);
      if (we_a_psum) begin
        if (wr_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_write: addr %0d data %h, nothing expected", addr_a_psum, wdata_a_psum);
        end else begin
          e = wr_q.pop_front();
          chk("write", {addr_a_psum, wdata_a_psum}, {e.addr, e.data});
        end
      end
      if (rd_valid) begin
        if (rd_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_rd_valid: data %h, nothing expected", rd_data);
        end else begin
          d = rd_q.pop_front();
          chk("drain_data", rd_data, d);
        end
      end
    end
  end

  task automatic check_reset_vals(input string tag);
    chk({tag, "_flags"}, {in_ready, rd_gnt, rd_valid, busy, we_a_psum, re_b_psum, re_bias},
        7'b1000000);
    chk({tag, "_addrs"}, {addr_b_psum, addr_a_psum, raddr_bias}, '0);
    chk({tag, "_data"}, {wdata_a_psum, rd_data}, '0);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge core_clk);
      #1;
    end
  endtask

  // Present one request for one cycle, check its read issue, queue the hand-computed write
  task automatic issue(input logic first, input logic last, input logic [AW-1:0] addr,
                       input logic [DW-1:0] data, input logic [BW-1:0] bidx,
                       input logic [DW-1:0] exp);
    in_valid    = 1'b1;
    in_first    = first;
    in_last     = last;
    in_addr     = addr;
    in_data     = data;
    in_bias_idx = bidx;
    wr_q.push_back('{addr: addr, data: exp});
    @(negedge core_clk);
    chk("in_ready", in_ready, 1'b1);
    chk("busy_at_accept", busy, 1'b1);
    if (first) chk("bias_read", {re_bias, re_b_psum, raddr_bias}, {2'b10, bidx});
    else       chk("psum_read", {re_b_psum, re_bias, addr_b_psum}, {2'b10, addr});
    @(posedge core_clk);
    #1;
    in_valid = 1'b0;
  endtask

  initial begin
    core_reset  = 1'b1;
    in_valid    = 1'b0;
    in_first    = 1'b0;
    in_last     = 1'b0;
    in_data     = '0;
    in_addr     = '0;
    in_bias_idx = '0;
    rd_req      = 1'b0;
    rd_addr     = '0;

    // Reset values
    repeat (2) @(posedge core_clk);
    @(negedge core_clk);
    check_reset_vals("reset");
    @(posedge core_clk);
    #1;
    core_reset = 1'b0;

    // First pass: 5 + bias 3
    issue(1'b1, 1'b0, 18'd10, 16'd5, 9'd7, 16'd8);
    idle(1);

    // Back-to-back same address: second operand must come from the forward path
    issue(1'b0, 1'b0, 18'd20, 16'd1, 9'd0, 16'd101);
    issue(1'b0, 1'b0, 18'd20, 16'd2, 9'd0, 16'd103);

    // Positive and negative saturation
    issue(1'b0, 1'b0, 18'd30, 16'h0100, 9'd0, 16'h7FFF);
    issue(1'b0, 1'b0, 18'd31, 16'hFF00, 9'd0, 16'h8000);

    // ReLU on last pass
    issue(1'b0, 1'b1, 18'd40, 16'd5, 9'd0, 16'd0);
    issue(1'b0, 1'b1, 18'd41, 16'd5, 9'd0, 16'd25);
    idle(2);

    // Starvation: drain waits through exactly 8 accepts, then wins
    rd_req  = 1'b1;
    rd_addr = 18'd50;
    for (int k = 0; k < 9; k++) begin
      in_valid = 1'b1;
      in_first = 1'b0;
      in_last  = 1'b0;
      in_addr  = AW'(60 + k);
      in_data  = DW'(k + 1);
      if (k < 8) wr_q.push_back('{addr: AW'(60 + k), data: DW'(k + 1)});
      else       rd_q.push_back(16'h1234);
      @(negedge core_clk);
      if (k < 8) chk("starve_wait", {rd_gnt, in_ready}, 2'b01);
      else       chk("starve_grant", {rd_gnt, in_ready, addr_b_psum}, {2'b10, 18'd50});
      @(posedge core_clk);
      #1;
    end
    rd_req   = 1'b0;
    in_valid = 1'b0;
    @(negedge core_clk);
    chk("rd_valid_after_gnt", rd_valid, 1'b1);
    idle(2);

    // Reset the cycle after an accept: the pending write must be dropped
    in_valid = 1'b1;
    in_first = 1'b0;
    in_last  = 1'b0;
    in_addr  = 18'd70;
    in_data  = 16'd9;
    @(posedge core_clk);
    #1;
    in_valid   = 1'b0;
    core_reset = 1'b1;
    @(negedge core_clk);
    chk("reset_no_write", we_a_psum, 1'b0);
    @(posedge core_clk);
    #1;
    core_reset = 1'b0;
    @(negedge core_clk);
    check_reset_vals("post_reset");
    @(posedge core_clk);
    #1;

    // Address 70 was never written, so a fresh accumulate sees the initial 0
    issue(1'b0, 1'b0, 18'd70, 16'd4, 9'd0, 16'd4);

    // Let outstanding expectations drain, bounded
    for (int i = 0; i < 20 && (wr_q.size() != 0 || rd_q.size() != 0); i++)
      @(posedge core_clk);
    if (wr_q.size() != 0 || rd_q.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL pending_expectations: %0d writes and %0d drains never seen",
               wr_q.size(), rd_q.size());
    end
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
